// File: rtl/fifo_rd_pkg.sv
// Shared constants for the FIFO read adapter: widths, buffer depth and
// the occupancy encoding of the two-entry output buffer.
package fifo_rd_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int BUF_DEPTH     = 2;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    // A new read may only be issued if every word already owed to the buffer still fits.
    function automatic logic can_issue(input logic [1:0] occ, input logic inflight, input logic pop);
        logic [2:0] pending;
        pending = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
        return pending < 3'(BUF_DEPTH);
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order output buffer; entry e0 is always the head.
//
//   state     | meaning
//   OCC_EMPTY | no word held, head not valid
//   OCC_ONE   | e0 holds the head
//   OCC_TWO   | e0 holds the head, e1 holds the next word
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic             overflow
);

    logic [WIDTH-1:0] e0;
    logic [WIDTH-1:0] e1;

    assign head     = e0;
    assign overflow = push & !pop & (count == OCC_TWO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= OCC_EMPTY;
            e0    <= '0;
            e1    <= '0;
        end else if (flush) begin
            count <= OCC_EMPTY;
            e0    <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    case (count)
                        OCC_EMPTY: begin
                            e0    <= push_data;
                            count <= OCC_ONE;
                        end
                        OCC_ONE: begin
                            e1    <= push_data;
                            count <= OCC_TWO;
                        end
                        default: ;
                    endcase
                end
                2'b01: begin
                    if (count != OCC_EMPTY) begin
                        e0    <= e1;
                        count <= count - 2'd1;
                    end
                end
                2'b11: begin
                    case (count)
                        OCC_EMPTY: begin
                            e0    <= push_data;
                            count <= OCC_ONE;
                        end
                        OCC_ONE: e0 <= push_data;
                        default: begin
                            e0 <= e1;
                            e1 <= push_data;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_adapter.sv
// Converts a FIFO with one-cycle read latency into a valid/ready stream,
// issuing reads only when the returning word is guaranteed a buffer slot.
module fifo_rd_adapter
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic             o_fifo_re,
    input  logic             i_fifo_empty,
    input  logic [WIDTH-1:0] i_fifo_data,
    input  logic             i_fifo_underflow,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_err
);

    logic       inflight;
    logic       pop;
    logic       push;
    logic       overflow;
    logic [1:0] count;

    assign o_valid   = (count != OCC_EMPTY);
    assign pop       = o_valid & i_ready;
    assign push      = inflight & !i_flush;
    assign o_fifo_re = !i_rst & !i_fifo_empty & !i_flush & can_issue(count, inflight, pop);

    fifo_rd_skid #(.WIDTH(WIDTH)) u_skid (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (push),
        .push_data (i_fifo_data),
        .pop       (pop),
        .flush     (i_flush),
        .head      (o_data),
        .count     (count),
        .overflow  (overflow)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            inflight <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            inflight <= o_fifo_re;
            o_err    <= o_err | i_fifo_underflow | overflow;
        end
    end

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Bench for fifo_rd_adapter: directed cycle tables, hand sequences for reset
// and error corners, and random traffic against an in-order scoreboard.
module tb_fifo_rd_adapter;

    localparam int W = 8;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         o_fifo_re;
    logic         i_fifo_empty;
    logic [W-1:0] i_fifo_data;
    logic         i_fifo_underflow = 1'b0;
    logic         i_flush = 1'b0;
    logic         o_valid;
    logic         i_ready = 1'b0;
    logic [W-1:0] o_data;
    logic         o_err;

    int total = 0;
    int bad   = 0;

    fifo_rd_adapter #(.WIDTH(W)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .o_fifo_re        (o_fifo_re),
        .i_fifo_empty     (i_fifo_empty),
        .i_fifo_data      (i_fifo_data),
        .i_fifo_underflow (i_fifo_underflow),
        .i_flush          (i_flush),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_data           (o_data),
        .o_err            (o_err)
    );

    always #5 i_clk = ~i_clk;

    // FIFO model: data appears the cycle after the read strobe is sampled
    logic [7:0] mem [256];
    logic [7:0] rd_ptr = 8'd0;
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] fdata  = 8'd0;
    logic       re_neg = 1'b0;

    assign i_fifo_empty = (rd_ptr == wr_ptr);
    assign i_fifo_data  = fdata;

    always @(negedge i_clk) re_neg <= o_fifo_re;
    always @(posedge i_clk) begin
        if (re_neg) begin
            fdata  <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 8'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input logic [7:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    // Scoreboard: words read from the FIFO and not yet delivered, in read order
    logic [7:0] exp_q[$];
    int         rst_cnt = 0;
    int         rst_seen = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic       sb_on = 1'b0;

    always @(posedge i_rst) rst_cnt++;

    always @(negedge i_clk) begin
        logic [7:0] want;
        if (rst_cnt != rst_seen) begin
            exp_q.delete();
            rst_seen = rst_cnt;
            prev_hold = 1'b0;
        end
        if (sb_on && !i_rst) begin
            if (prev_hold) begin
                check("sb_hold_valid", 32'(o_valid), 32'd1);
                check("sb_hold_data", 32'(o_data), 32'(prev_data));
            end
            check("sb_outstanding_le2", 32'(exp_q.size() <= 2), 32'd1);
            if (o_valid) begin
                check("sb_valid_has_word", 32'(exp_q.size() != 0), 32'd1);
                if (i_ready && exp_q.size() != 0) begin
                    want = exp_q.pop_front();
                    check("sb_order", 32'(o_data), 32'(want));
                end
            end
            if (o_fifo_re) exp_q.push_back(mem[rd_ptr]);
            if (i_flush) exp_q.delete();
            prev_hold = o_valid && !i_ready && !i_flush;
            prev_data = o_data;
        end else begin
            prev_hold = 1'b0;
        end
    end

    typedef struct {
        logic       ready;
        logic       flush;
        logic       exp_re;
        logic       exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, input logic f, input logic re, input logic v, input logic [7:0] d);
        vec_t e;
        e.ready = r; e.flush = f; e.exp_re = re; e.exp_valid = v; e.exp_data = d;
        vt.push_back(e);
    endtask

    // Called #1 after a rising edge; one table row per clock cycle.
    task automatic run_vectors(input string tag);
        for (int i = 0; i < vt.size(); i++) begin
            i_ready = vt[i].ready;
            i_flush = vt[i].flush;
            @(negedge i_clk);
            check($sformatf("%s_c%0d_re", tag, i), 32'(o_fifo_re), 32'(vt[i].exp_re));
            check($sformatf("%s_c%0d_valid", tag, i), 32'(o_valid), 32'(vt[i].exp_valid));
            if (vt[i].exp_valid)
                check($sformatf("%s_c%0d_data", tag, i), 32'(o_data), 32'(vt[i].exp_data));
            @(posedge i_clk);
            #1;
        end
        i_flush = 1'b0;
        vt.delete();
    endtask

    // Leaves reset asserted at #1 after an edge with the FIFO emptied.
    task automatic do_reset();
        i_rst   = 1'b1;
        i_flush = 1'b0;
        i_ready = 1'b0;
        wr_ptr  = rd_ptr;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        logic [7:0] got[$];
        int first_v;
        int last_v;
        int n;

        do_reset();
        check("reset_valid", 32'(o_valid), 32'd0);
        check("reset_data", 32'(o_data), 32'd0);
        check("reset_err", 32'(o_err), 32'd0);
        check("reset_re_gated", 32'(o_fifo_re), 32'd0);
        sb_on = 1'b1;

        // first-word latency
        load(8'h11);
        i_rst = 1'b0;
        add(0, 0, 1, 0, 8'h00);
        add(0, 0, 0, 0, 8'h00);
        add(0, 0, 0, 1, 8'h11);
        add(1, 0, 0, 1, 8'h11);
        add(0, 0, 0, 0, 8'h00);
        run_vectors("lat");
        check("lat_err", 32'(o_err), 32'd0);

        // backpressure: two reads then stall, then drain
        do_reset();
        for (int i = 0; i < 5; i++) load(8'hA0 + 8'(i));
        i_rst = 1'b0;
        add(0, 0, 1, 0, 8'h00);
        add(0, 0, 1, 0, 8'h00);
        add(0, 0, 0, 1, 8'hA0);
        add(0, 0, 0, 1, 8'hA0);
        add(0, 0, 0, 1, 8'hA0);
        add(1, 0, 1, 1, 8'hA0);
        add(1, 0, 1, 1, 8'hA1);
        add(1, 0, 1, 1, 8'hA2);
        add(1, 0, 0, 1, 8'hA3);
        add(1, 0, 0, 1, 8'hA4);
        add(1, 0, 0, 0, 8'h00);
        run_vectors("bp");

        // flush while a word returns with one word buffered
        do_reset();
        load(8'hB0); load(8'hB1); load(8'hB2);
        i_rst = 1'b0;
        add(0, 0, 1, 0, 8'h00);
        add(0, 0, 1, 0, 8'h00);
        add(0, 1, 0, 1, 8'hB0);
        add(0, 0, 1, 0, 8'h00);
        add(0, 0, 0, 0, 8'h00);
        add(0, 0, 0, 1, 8'hB2);
        add(1, 0, 0, 1, 8'hB2);
        add(0, 0, 0, 0, 8'h00);
        run_vectors("flush");

        // 8-word burst with ready held high
        do_reset();
        for (int i = 0; i < 8; i++) load(8'h30 + 8'(i));
        i_rst = 1'b0;
        i_ready = 1'b1;
        first_v = -1;
        last_v = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge i_clk);
            if (o_valid) begin
                got.push_back(o_data);
                if (first_v < 0) first_v = c;
                last_v = c;
            end
            @(posedge i_clk);
            #1;
        end
        check("burst_count", 32'(got.size()), 32'd8);
        check("burst_first_cycle", 32'(first_v), 32'd2);
        check("burst_contiguous", 32'(last_v - first_v + 1), 32'd8);
        for (int i = 0; i < got.size(); i++)
            check($sformatf("burst_word%0d", i), 32'(got[i]), 32'h30 + 32'(i));
        @(negedge i_clk);
        check("burst_re_idle", 32'(o_fifo_re), 32'd0);
        check("burst_err", 32'(o_err), 32'd0);
        @(posedge i_clk);
        #1;

        // asynchronous reset pulse with the buffer full
        do_reset();
        for (int i = 0; i < 4; i++) load(8'hC0 + 8'(i));
        i_rst = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;
        check("areset_pre_valid", 32'(o_valid), 32'd1);
        check("areset_pre_data", 32'(o_data), 32'hC0);
        #1;
        i_rst = 1'b1;
        #1;
        check("areset_valid", 32'(o_valid), 32'd0);
        check("areset_data", 32'(o_data), 32'd0);
        check("areset_err", 32'(o_err), 32'd0);
        check("areset_re", 32'(o_fifo_re), 32'd0);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("areset_restart_re", 32'(o_fifo_re), 32'd1);
        check("areset_restart_valid", 32'(o_valid), 32'd0);
        repeat (2) @(negedge i_clk);
        check("areset_restart_word", 32'(o_data), 32'hC2);
        check("areset_restart_v", 32'(o_valid), 32'd1);
        @(posedge i_clk);
        #1;

        // underflow sets a sticky error
        i_fifo_underflow = 1'b1;
        @(posedge i_clk);
        #1;
        i_fifo_underflow = 1'b0;
        check("uf_err_set", 32'(o_err), 32'd1);
        repeat (5) @(posedge i_clk);
        #1;
        check("uf_err_sticky", 32'(o_err), 32'd1);
        do_reset();
        check("uf_err_cleared", 32'(o_err), 32'd0);
        i_rst = 1'b0;

        // random traffic, checked by the scoreboard
        for (int c = 0; c < 3000; c++) begin
            if (c < 1000)      i_ready = ($urandom_range(0, 3) != 0);
            else if (c < 2000) i_ready = ($urandom_range(0, 3) == 0);
            else               i_ready = $urandom_range(0, 1) != 0;
            i_flush = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 2) != 0 && (wr_ptr - rd_ptr) < 8'd200)
                load(8'($urandom));
            @(posedge i_clk);
            #1;
        end
        i_flush = 1'b0;
        i_ready = 1'b1;
        n = 0;
        while ((!i_fifo_empty || o_valid || exp_q.size() != 0) && n < 600) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check("drain_done", 32'(n < 600), 32'd1);
        check("rand_err", 32'(o_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
